// File: rtl/cpu_datapath_p.sv
// cpu_datapath_p
//   Parametrised CPU datapath: PC, IR, register file, add/sub ALU, N/Z flags
//   and a memory bus master. The control FSM issues coarse commands
//   (NOP/FETCH/EXEC/RESET_PC); this block decodes IR and completes each
//   instruction itself, stalling on i_mem_waitrequest for memory accesses.
//
// Ports
//   clk                clock, all state on posedge
//   reset              asynchronous active-low reset
//   i_cmd_valid/i_cmd  command offer (0=NOP 1=FETCH 2=EXEC 3=RESET_PC)
//   o_cmd_ready        high only when idle
//   o_cmd_done         one-cycle pulse after a command completes
//   o_illegal          pulses with o_cmd_done for an undefined EXEC opcode
//   o_opcode           IR[4:0]
//   o_N, o_Z           flags from the last add/sub/cmp
//   o_mem_*            registered memory request (addr/rd/wr/wrdata)
//   i_mem_rddata       read data, taken when rd high and waitrequest low
//   i_mem_waitrequest  stall; an access completes on the first edge it is low
module cpu_datapath_p #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned NREGS    = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 2,
    parameter int unsigned LINK_REG = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    output logic              o_cmd_ready,
    output logic              o_cmd_done,
    output logic              o_illegal,
    output logic [4:0]        o_opcode,
    output logic              o_N,
    output logic              o_Z,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_wrdata,
    input  logic [DATA_W-1:0] i_mem_rddata,
    input  logic              i_mem_waitrequest
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LD, K_ST} kind_t;
    typedef enum logic [1:0] {CMD_NOP, CMD_FETCH, CMD_EXEC, CMD_RESET_PC} cmd_t;

    state_t            state, state_nxt;
    kind_t             kind;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic              flag_n, flag_z;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rf8 [8];

    // Full 8-entry read view: indices beyond NREGS read as zero.
    for (genvar g = 0; g < 8; g++) begin : g_rd
        if (g < NREGS) begin : g_real
            assign rf8[g] = regs[g];
        end else begin : g_zero
            assign rf8[g] = '0;
        end
    end

    logic [4:0]        op;
    logic [2:0]        rx_i, ry_i;
    logic [7:0]        imm8;
    logic [10:0]       imm11;
    logic [DATA_W-1:0] rx_val, ry_val, simm8, alu_b, alu_res;
    logic [ADDR_W-1:0] rel_off, br_tgt;

    assign op      = ir[4:0];
    assign rx_i    = ir[7:5];
    assign ry_i    = ir[10:8];
    assign imm8    = ir[15:8];
    assign imm11   = ir[15:5];
    assign rx_val  = rf8[rx_i];
    assign ry_val  = rf8[ry_i];
    assign simm8   = {{(DATA_W-8){imm8[7]}}, imm8};
    assign alu_b   = op[4] ? simm8 : ry_val;
    assign alu_res = (op[1:0] == 2'b01) ? rx_val + alu_b : rx_val - alu_b;
    assign rel_off = ADDR_W'({{ADDR_W{imm11[10]}}, imm11, 1'b0});
    assign br_tgt  = op[4] ? pc + rel_off : ADDR_W'(rx_val);

    logic accept, exec_go, mem_done;
    assign accept   = i_cmd_valid && (state == S_IDLE);
    assign exec_go  = accept && (i_cmd == CMD_EXEC);
    assign mem_done = (state == S_MEM) && !i_mem_waitrequest;

    // Instruction decode; effects are applied only when exec_go is high.
    logic              ex_we, ex_flags, ex_pc_we, ex_ld, ex_st, ex_ill;
    logic [2:0]        ex_wa;
    logic [DATA_W-1:0] ex_wd;

    always_comb begin
        ex_we    = 1'b0;
        ex_wa    = rx_i;
        ex_wd    = alu_res;
        ex_flags = 1'b0;
        ex_pc_we = 1'b0;
        ex_ld    = 1'b0;
        ex_st    = 1'b0;
        ex_ill   = 1'b0;
        case (op)
            5'b00000: begin ex_we = 1'b1; ex_wd = ry_val; end
            5'b10000: begin ex_we = 1'b1; ex_wd = simm8; end
            5'b10110: begin
                ex_we       = 1'b1;
                ex_wd       = rx_val;
                ex_wd[15:8] = imm8;
            end
            5'b00001, 5'b10001,
            5'b00010, 5'b10010: begin ex_we = 1'b1; ex_flags = 1'b1; end
            5'b00011, 5'b10011: ex_flags = 1'b1;
            5'b00100:           ex_ld = 1'b1;
            5'b00101:           ex_st = 1'b1;
            5'b01000, 5'b11000: ex_pc_we = 1'b1;
            5'b01001, 5'b11001: ex_pc_we = flag_z;
            5'b01010, 5'b11010: ex_pc_we = flag_n;
            5'b01100, 5'b11100: begin
                ex_pc_we = 1'b1;
                ex_we    = 1'b1;
                ex_wa    = 3'(LINK_REG);
                ex_wd    = DATA_W'(pc);
            end
            default:            ex_ill = 1'b1;
        endcase
    end

    // Single register write port: load completion and EXEC never coincide.
    logic              rf_we;
    logic [2:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rx_i;
        rf_wd = ex_wd;
        if (mem_done && kind == K_LD) begin
            rf_we = 1'b1;
            rf_wd = i_mem_rddata;
        end else if (exec_go && ex_we) begin
            rf_we = 1'b1;
            rf_wa = ex_wa;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_cmd_valid) begin
                if (i_cmd == CMD_FETCH || (i_cmd == CMD_EXEC && (ex_ld || ex_st)))
                    state_nxt = S_MEM;
                else
                    state_nxt = S_DONE;
            end
            S_MEM:  if (!i_mem_waitrequest) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++)
                if (rf_we && rf_wa == 3'(i)) regs[i] <= rf_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= ADDR_W'(RESET_PC);
            ir           <= '0;
            flag_n       <= 1'b0;
            flag_z       <= 1'b0;
            kind         <= K_FETCH;
            o_mem_addr   <= '0;
            o_mem_rd     <= 1'b0;
            o_mem_wr     <= 1'b0;
            o_mem_wrdata <= '0;
            o_illegal    <= 1'b0;
        end else begin
            // EXEC can only be accepted in IDLE, so this is high exactly in DONE.
            o_illegal <= exec_go && ex_ill;
            if (accept) begin
                case (i_cmd)
                    CMD_FETCH: begin
                        o_mem_addr <= pc;
                        o_mem_rd   <= 1'b1;
                        kind       <= K_FETCH;
                    end
                    CMD_RESET_PC: begin
                        pc <= ADDR_W'(RESET_PC);
                        ir <= '0;
                    end
                    CMD_EXEC: begin
                        if (ex_ld) begin
                            o_mem_addr <= ADDR_W'(ry_val);
                            o_mem_rd   <= 1'b1;
                            kind       <= K_LD;
                        end
                        if (ex_st) begin
                            o_mem_addr   <= ADDR_W'(ry_val);
                            o_mem_wr     <= 1'b1;
                            o_mem_wrdata <= rx_val;
                            kind         <= K_ST;
                        end
                        if (ex_pc_we) pc <= br_tgt;
                        if (ex_flags) begin
                            flag_n <= alu_res[DATA_W-1];
                            flag_z <= (alu_res == '0);
                        end
                    end
                    default: ;
                endcase
            end
            if (mem_done) begin
                o_mem_rd <= 1'b0;
                o_mem_wr <= 1'b0;
                if (kind == K_FETCH) begin
                    ir <= i_mem_rddata[15:0];
                    pc <= pc + ADDR_W'(PC_STEP);
                end
            end
        end
    end

    assign o_cmd_ready = (state == S_IDLE);
    assign o_cmd_done  = (state == S_DONE);
    assign o_opcode    = ir[4:0];
    assign o_N         = flag_n;
    assign o_Z         = flag_z;

endmodule

// File: tb/tb_cpu_datapath_p.sv
// tb_cpu_datapath_p
//   Directed scenarios followed by random instruction streams, checked
//   against an arithmetic reference model of the programmer-visible state
//   (registers, PC, flags). Register contents are observed through store
//   instructions and load/store addresses on the memory bus.
module tb_cpu_datapath_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready, cmd_done, illegal;
    logic [4:0]  opcode;
    logic        flag_n, flag_z;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_wrdata;
    logic [15:0] mem_rddata;
    logic        mem_waitreq;

    always #5 clk = ~clk;

    cpu_datapath_p #(
        .DATA_W(16), .ADDR_W(16), .NREGS(8),
        .RESET_PC(0), .PC_STEP(2), .LINK_REG(7)
    ) dut (
        .clk(clk), .reset(reset),
        .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(cmd_ready), .o_cmd_done(cmd_done), .o_illegal(illegal),
        .o_opcode(opcode), .o_N(flag_n), .o_Z(flag_z),
        .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
        .o_mem_wrdata(mem_wrdata), .i_mem_rddata(mem_rddata),
        .i_mem_waitrequest(mem_waitreq)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state.
    int unsigned mr [8];
    int unsigned mpc;
    bit          mn, mz;

    // Bus observations from the most recent command.
    logic [15:0] cap_addr, cap_wrdata, last_fetch;
    logic        cap_rd, cap_wr, cap_ill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] rr(input int op, input int rx, input int ry);
        logic [4:0] o; logic [2:0] x, y;
        o = op[4:0]; x = rx[2:0]; y = ry[2:0];
        return {5'b0, y, x, o};
    endfunction

    function automatic logic [15:0] ri(input int op, input int rx, input int imm);
        logic [4:0] o; logic [2:0] x; logic [7:0] m;
        o = op[4:0]; x = rx[2:0]; m = imm[7:0];
        return {m, x, o};
    endfunction

    function automatic logic [15:0] rj(input int op, input int imm);
        logic [4:0] o; logic [10:0] m;
        o = op[4:0]; m = imm[10:0];
        return {m, o};
    endfunction

    function automatic int unsigned sx8(input int unsigned v);
        return (v >= 128) ? v + 'hFF00 : v;
    endfunction

    // Offer one command at a negedge, then act as memory slave until done.
    task automatic send(input logic [1:0] c, input int unsigned waits,
                        input logic [15:0] rdata, input bit poke);
        @(negedge clk);
        chk("ready_idle", cmd_ready, 1);
        chk("done_idle", cmd_done, 0);
        cmd_valid = 1'b1;
        cmd       = c;
        @(negedge clk);
        cmd_valid = poke;          // RESET_PC offered while busy must be ignored
        cmd       = 2'd3;
        cap_rd     = mem_rd;
        cap_wr     = mem_wr;
        cap_addr   = mem_addr;
        cap_wrdata = mem_wrdata;
        if (cap_rd || cap_wr) begin
            chk("rd_wr_excl", cap_rd & cap_wr, 0);
            for (int unsigned w = 0; w <= waits; w++) begin
                if (w > 0) begin
                    chk("addr_held", mem_addr, cap_addr);
                    chk("req_held", {mem_rd, mem_wr}, {cap_rd, cap_wr});
                    chk("busy_not_ready", cmd_ready, 0);
                end
                mem_waitreq = (w < waits);
                mem_rddata  = (w < waits) ? 16'($urandom) : rdata;
                @(negedge clk);
            end
            mem_waitreq = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("done_pulse", cmd_done, 1);
        chk("req_dropped", {mem_rd, mem_wr}, 0);
        cap_ill = illegal;
    endtask

    // FETCH the word then EXEC it, comparing bus activity and flags with the model.
    task automatic run_instr(input logic [15:0] instr, input logic [15:0] ld_val,
                             input int unsigned fwaits);
        int unsigned op, rx, ry, imm8, imm11, a, b, r, tgt, base;
        int          s;
        bit          ill, take;
        send(2'd1, fwaits, instr, 1'b1);
        chk("fetch_rd", {cap_rd, cap_wr}, 2'b10);
        chk("fetch_addr", cap_addr, mpc);
        last_fetch = cap_addr;
        mpc = (mpc + 2) & 'hFFFF;
        chk("opcode", opcode, instr[4:0]);

        op = instr[4:0]; rx = instr[7:5]; ry = instr[10:8];
        imm8 = instr[15:8]; imm11 = instr[15:5];
        base = op % 16;
        ill = 1'b0;
        send(2'd2, $urandom_range(0, 2), ld_val, 1'b1);
        if (op == 4) begin
            chk("ld_req", {cap_rd, cap_wr}, 2'b10);
            chk("ld_addr", cap_addr, mr[ry]);
        end else if (op == 5) begin
            chk("st_req", {cap_rd, cap_wr}, 2'b01);
            chk("st_addr", cap_addr, mr[ry]);
            chk("st_data", cap_wrdata, mr[rx]);
        end else begin
            chk("exec_no_mem", {cap_rd, cap_wr}, 2'b00);
        end

        case (op)
            0:  mr[rx] = mr[ry];
            16: mr[rx] = sx8(imm8);
            22: mr[rx] = (mr[rx] & 'hFF) | (imm8 << 8);
            1, 17, 2, 18, 3, 19: begin
                a = mr[rx];
                b = (op >= 16) ? sx8(imm8) : mr[ry];
                r = (base == 1) ? (a + b) & 'hFFFF : (a + 'h10000 - b) & 'hFFFF;
                mn = (r >= 'h8000);
                mz = (r == 0);
                if (base != 3) mr[rx] = r;
            end
            4: mr[rx] = ld_val;
            5: ;
            8, 24, 9, 25, 10, 26, 12, 28: begin
                take = (base == 8) || (base == 12) || (base == 9 && mz) || (base == 10 && mn);
                s    = (imm11 >= 1024) ? int'(imm11) - 2048 : int'(imm11);
                tgt  = (op >= 16) ? 32'(int'(mpc) + 2 * s) & 'hFFFF : mr[rx];
                if (take) begin
                    if (base == 12) mr[7] = mpc;
                    mpc = tgt;
                end
            end
            default: ill = 1'b1;
        endcase
        chk("illegal", cap_ill, ill);
        chk("flag_N", flag_n, mn);
        chk("flag_Z", flag_z, mz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        cmd_valid   = 1'b0;
        cmd         = 2'd0;
        mem_rddata  = '0;
        mem_waitreq = 1'b1;
        for (int i = 0; i < 8; i++) mr[i] = 0;
        mpc = 0; mn = 0; mz = 0;
        repeat (2) @(negedge clk);

        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", cmd_done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_mem", {mem_rd, mem_wr, mem_addr, mem_wrdata}, 0);
        chk("rst_flags", {flag_n, flag_z, opcode}, 0);
        reset = 1'b1;

        // Reset while a fetch is stalled.
        @(negedge clk);
        cmd_valid = 1'b1; cmd = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("s1_rd_pending", mem_rd, 1);
        #2 reset = 1'b0;
        #1 chk("s1_rd_drop", mem_rd, 0);
        chk("s1_addr_clr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        chk("s1_ready_after", cmd_ready, 1);

        // mvi R0,5 fetched with two wait states.
        run_instr(16'h0510, 16'h0, 2);
        chk("s2_fetch_pc0", last_fetch, 16'h0000);
        run_instr(rr(5, 0, 1), 16'h0, 0);
        chk("s2_pc2", last_fetch, 16'h0002);
        chk("s2_r0", cap_wrdata, 16'h0005);

        // Overflow into the sign bit, then compare equal.
        run_instr(ri(16, 1, 'hFF), 16'h0, 1);
        run_instr(ri(22, 1, 'h7F), 16'h0, 0);
        run_instr(ri(17, 1, 1), 16'h0, 0);
        chk("s3_add_NZ", {flag_n, flag_z}, 2'b10);
        run_instr(rr(5, 1, 0), 16'h0, 0);
        chk("s3_r1", cap_wrdata, 16'h8000);
        run_instr(rr(3, 1, 1), 16'h0, 0);
        chk("s3_cmp_NZ", {flag_n, flag_z}, 2'b01);
        run_instr(rr(5, 1, 0), 16'h0, 0);
        chk("s3_r1_kept", cap_wrdata, 16'h8000);

        // Store then load through R2.
        run_instr(ri(16, 2, 'h40), 16'h0, 0);
        run_instr(ri(16, 3, 'hEF), 16'h0, 0);
        run_instr(ri(22, 3, 'hBE), 16'h0, 0);
        run_instr(rr(5, 3, 2), 16'h0, 1);
        chk("s4_st_addr", cap_addr, 16'h0040);
        chk("s4_st_data", cap_wrdata, 16'hBEEF);
        run_instr(rr(4, 4, 2), 16'hBEEF, 0);
        run_instr(rr(5, 4, 2), 16'h0, 0);
        chk("s4_r4", cap_wrdata, 16'hBEEF);

        // call with imm11=-4 from PC=0x10 (fetched at 0x0E), then untaken jz.
        run_instr(ri(16, 5, 'h0E), 16'h0, 0);
        run_instr(rr(8, 5, 0), 16'h0, 0);
        run_instr(rj(28, -4), 16'h0, 0);
        chk("s5_call_at", last_fetch, 16'h000E);
        run_instr(rr(3, 0, 4), 16'h0, 0);
        chk("s5_call_tgt", last_fetch, 16'h0008);
        run_instr(rj(25, 5), 16'h0, 0);
        run_instr(rr(5, 7, 0), 16'h0, 0);
        chk("s5_jz_untaken", last_fetch, 16'h000C);
        chk("s5_link", cap_wrdata, 16'h0010);

        // Undefined opcode.
        run_instr(16'h001F, 16'h0, 1);
        chk("s6_illegal", cap_ill, 1);
        run_instr(16'h0AFF, 16'h0, 0);
        chk("s6_illegal2", cap_ill, 1);

        // Random instruction stream, biased toward stores for visibility.
        for (int k = 0; k < 150; k++) begin
            logic [15:0] instr;
            instr = 16'($urandom);
            if ($urandom_range(0, 3) == 0) instr[4:0] = 5'b00101;
            run_instr(instr, 16'($urandom), $urandom_range(0, 2));
        end

        // NOP and RESET_PC commands.
        send(2'd0, 0, 16'h0, 1'b0);
        chk("nop_no_mem", {cap_rd, cap_wr}, 2'b00);
        send(2'd3, 0, 16'h0, 1'b0);
        chk("rstpc_opcode", opcode, 5'd0);
        mpc = 0;
        run_instr(rr(5, 0, 1), 16'h0, 0);
        chk("rstpc_fetch", last_fetch, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
